// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//
// Conditions the raw direction pushbuttons (bit 0 = up, 1 = down, 2 = left,
// 3 = right) before they reach the HPS button PIO. Each key is synchronised
// with two flops, then debounced by its own FSM and counter. Each key gives a
// clean level, a one-cycle event pulse on the accepted press and on every
// auto-repeat, and a one-cycle pulse on the accepted release.
//
// Ports:
//   clk          system clock (50 MHz)
//   reset_n      asynchronous active-low reset
//   key_n        raw pushbuttons, active-low, asynchronous to clk
//   btn_level    debounced state, 1 = pressed (registered)
//   btn_event    one-cycle pulse on accepted press and each repeat (registered)
//   btn_release  one-cycle pulse on accepted release (registered)
//
// Per-button FSM state is held in g_btn[i].state_q so that checkers can bind
// to it hierarchically.
// ---------------------------------------------------------------------------
module button_conditioner #(
    parameter int NUM_BTN             = 4,
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000,
    parameter bit REPEAT_EN           = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] key_n,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_event,
    output logic [NUM_BTN-1:0] btn_release
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRESS_DB = 3'd1,
        S_HELD     = 3'd2,
        S_REPEAT   = 3'd3,
        S_REL_DB   = 3'd4
    } state_t;

    // The counter must hold the largest terminal value. Keep it at least
    // 1 bit wide even when every cycle parameter is 1.
    localparam int MAX_AB  = (DEBOUNCE_CYCLES > REPEAT_DELAY_CYCLES) ?
                             DEBOUNCE_CYCLES : REPEAT_DELAY_CYCLES;
    localparam int MAX_CYC = (MAX_AB > REPEAT_RATE_CYCLES) ? MAX_AB : REPEAT_RATE_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Two-flop synchroniser. It resets to 1 so that every key reads as
    // released.
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             event_q, event_d;
        logic             release_q, release_d;
        logic             pressed;

        assign pressed = ~sync2[i];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q   <= S_IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                event_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                event_q   <= event_d;
                release_q <= release_d;
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            event_d   = 1'b0;
            release_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    level_d = 1'b0;
                    if (pressed) begin
                        state_d = S_PRESS_DB;
                        cnt_d   = '0;
                    end
                end
                S_PRESS_DB: begin
                    if (!pressed) begin
                        // A bounce is rejected silently.
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = S_HELD;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        event_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HELD: begin
                    if (!pressed) begin
                        state_d = S_REL_DB;
                        cnt_d   = '0;
                    end else if (REPEAT_EN && (cnt_q == DLY_LAST)) begin
                        state_d = S_REPEAT;
                        cnt_d   = '0;
                        event_d = 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        // The counter saturates so that a long hold with
                        // repeat disabled cannot wrap.
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (!pressed) begin
                        state_d = S_REL_DB;
                        cnt_d   = '0;
                    end else if (cnt_q == RATE_LAST) begin
                        cnt_d   = '0;
                        event_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_REL_DB: begin
                    if (pressed) begin
                        // A release bounce returns to HELD with a fresh
                        // repeat delay and no new event.
                        state_d = S_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = S_IDLE;
                        cnt_d     = '0;
                        level_d   = 1'b0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign btn_level[i]   = level_q;
        assign btn_event[i]   = event_q;
        assign btn_release[i] = release_q;
    end

endmodule
